// File: rtl/id_ex_stage.sv
// ID/EX stage: decodes to an ALU function, forwards operands, registers EX controls, inserts load-use bubbles.
// Latency: one cycle from ID inputs to EX outputs.
// Backpressure: stall holds the EX register; hazard_stall (combinational) asks upstream to hold ID.
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif
`ifndef SHAMT_WIDTH
`define SHAMT_WIDTH 5
`endif
`ifndef ALU_ADD
`define ALU_ADD 4'd0
`endif
`ifndef ALU_SUB
`define ALU_SUB 4'd1
`endif
`ifndef ALU_SLL
`define ALU_SLL 4'd2
`endif

module id_ex_stage (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    id_valid,
    input  logic [5:0]              id_opcode,
    input  logic [5:0]              id_funct,
    input  logic [`SHAMT_WIDTH-1:0] id_shamt,
    input  logic [4:0]              id_rs,
    input  logic [4:0]              id_rt,
    input  logic [4:0]              id_rd,
    input  logic [`WORD_WIDTH-1:0]  id_rs_data,
    input  logic [`WORD_WIDTH-1:0]  id_rt_data,
    input  logic [15:0]             id_imm,
    input  logic                    stall,
    input  logic                    flush,
    input  logic                    exm_wr_en,
    input  logic [4:0]              exm_wr_addr,
    input  logic [`WORD_WIDTH-1:0]  exm_wr_data,
    input  logic                    wb_wr_en,
    input  logic [4:0]              wb_wr_addr,
    input  logic [`WORD_WIDTH-1:0]  wb_wr_data,
    output logic                    hazard_stall,
    output logic                    illegal_op,
    output logic                    ex_valid,
    output logic                    ex_wr_en,
    output logic                    ex_mem_rd,
    output logic                    ex_mem_wr,
    output logic                    ex_branch,
    output logic [4:0]              ex_wr_addr,
    output logic [3:0]              alu_function,
    output logic [`WORD_WIDTH-1:0]  alu_src1,
    output logic [`WORD_WIDTH-1:0]  alu_src2,
    output logic [`WORD_WIDTH-1:0]  ex_store_data,
    output logic [`SHAMT_WIDTH-1:0] shamt
);

    typedef struct packed {
        logic                    valid;
        logic                    wr_en;
        logic                    mem_rd;
        logic                    mem_wr;
        logic                    branch;
        logic [4:0]              wr_addr;
        logic [3:0]              fn;
        logic [`WORD_WIDTH-1:0]  src1;
        logic [`WORD_WIDTH-1:0]  src2;
        logic [`WORD_WIDTH-1:0]  store;
        logic [`SHAMT_WIDTH-1:0] shamt;
        logic [4:0]              rs_idx;
        logic [4:0]              rt_idx;
        logic                    rt_store;
    } ex_t;

    ex_t ex_q;
    ex_t bubble;
    ex_t cap;
    ex_t held;

    logic                   dec_legal;
    logic                   dec_imm;
    logic                   dec_mem_rd;
    logic                   dec_mem_wr;
    logic                   dec_branch;
    logic                   dec_wr;
    logic                   dec_reads_rt;
    logic                   dec_sll;
    logic [3:0]             dec_fn;
    logic [4:0]             dec_dest;
    logic [`WORD_WIDTH-1:0] rs_val;
    logic [`WORD_WIDTH-1:0] rt_val;
    logic [`WORD_WIDTH-1:0] imm_sext;
    logic                   load_pending;
    logic [4:0]             pend_addr;
    logic                   ex_match;
    logic                   pend_match;
    logic                   load_hazard;

    always_comb begin
        dec_legal    = 1'b1;
        dec_fn       = `ALU_ADD;
        dec_imm      = 1'b0;
        dec_mem_rd   = 1'b0;
        dec_mem_wr   = 1'b0;
        dec_branch   = 1'b0;
        dec_wr       = 1'b0;
        dec_dest     = 5'd0;
        dec_reads_rt = 1'b0;
        dec_sll      = 1'b0;
        case (id_opcode)
            6'h00: begin
                dec_reads_rt = 1'b1;
                dec_wr       = 1'b1;
                dec_dest     = id_rd;
                case (id_funct)
                    6'h20:   dec_fn = `ALU_ADD;
                    6'h22:   dec_fn = `ALU_SUB;
                    6'h00: begin
                        dec_fn  = `ALU_SLL;
                        dec_sll = 1'b1;
                    end
                    default: dec_legal = 1'b0;
                endcase
            end
            6'h08: begin
                dec_imm  = 1'b1;
                dec_wr   = 1'b1;
                dec_dest = id_rt;
            end
            6'h23: begin
                dec_imm    = 1'b1;
                dec_mem_rd = 1'b1;
                dec_wr     = 1'b1;
                dec_dest   = id_rt;
            end
            6'h2B: begin
                dec_imm      = 1'b1;
                dec_mem_wr   = 1'b1;
                dec_reads_rt = 1'b1;
            end
            6'h04: begin
                dec_fn       = `ALU_SUB;
                dec_branch   = 1'b1;
                dec_reads_rt = 1'b1;
            end
            default: dec_legal = 1'b0;
        endcase
    end

    // MEM-stage result is younger than the writeback port, so it takes priority.
    assign rs_val = (id_rs == 5'd0) ? '0 :
                    (exm_wr_en && exm_wr_addr == id_rs) ? exm_wr_data :
                    (wb_wr_en && wb_wr_addr == id_rs) ? wb_wr_data : id_rs_data;
    assign rt_val = (id_rt == 5'd0) ? '0 :
                    (exm_wr_en && exm_wr_addr == id_rt) ? exm_wr_data :
                    (wb_wr_en && wb_wr_addr == id_rt) ? wb_wr_data : id_rt_data;
    assign imm_sext = {{(`WORD_WIDTH-16){id_imm[15]}}, id_imm};

    assign ex_match   = ex_q.valid && ex_q.mem_rd && (ex_q.wr_addr != 5'd0) &&
                        ((id_rs == ex_q.wr_addr) || (dec_reads_rt && id_rt == ex_q.wr_addr));
    assign pend_match = load_pending && (pend_addr != 5'd0) &&
                        ((id_rs == pend_addr) || (dec_reads_rt && id_rt == pend_addr));
    assign load_hazard  = id_valid && !rst && !flush && !stall && (ex_match || pend_match);
    assign hazard_stall = load_hazard;

    always_comb begin
        bubble    = '0;
        bubble.fn = `ALU_ADD;
        cap       = bubble;
        if (id_valid && dec_legal) begin
            cap.valid    = 1'b1;
            cap.wr_en    = dec_wr && (dec_dest != 5'd0);
            cap.mem_rd   = dec_mem_rd;
            cap.mem_wr   = dec_mem_wr;
            cap.branch   = dec_branch;
            cap.wr_addr  = dec_dest;
            cap.fn       = dec_fn;
            cap.src1     = rs_val;
            cap.src2     = dec_imm ? imm_sext : rt_val;
            cap.store    = dec_mem_wr ? rt_val : '0;
            cap.shamt    = dec_sll ? id_shamt : '0;
            cap.rs_idx   = id_rs;
            cap.rt_idx   = dec_reads_rt ? id_rt : 5'd0;
            cap.rt_store = dec_mem_wr;
        end
        // A held entry keeps snooping writeback so it leaves the stall with current operands.
        held = ex_q;
        if (ex_q.valid && wb_wr_en && wb_wr_addr != 5'd0) begin
            if (wb_wr_addr == ex_q.rs_idx) begin
                held.src1 = wb_wr_data;
            end
            if (wb_wr_addr == ex_q.rt_idx) begin
                if (ex_q.rt_store) begin
                    held.store = wb_wr_data;
                end else begin
                    held.src2 = wb_wr_data;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            ex_q         <= bubble;
            load_pending <= 1'b0;
            pend_addr    <= 5'd0;
            illegal_op   <= 1'b0;
        end else if (stall) begin
            ex_q       <= held;
            illegal_op <= 1'b0;
        end else if (load_hazard) begin
            ex_q         <= bubble;
            load_pending <= ex_match;
            pend_addr    <= ex_q.wr_addr;
            illegal_op   <= 1'b0;
        end else begin
            ex_q         <= cap;
            load_pending <= 1'b0;
            illegal_op   <= id_valid && !dec_legal;
        end
    end

    assign ex_valid      = ex_q.valid;
    assign ex_wr_en      = ex_q.wr_en;
    assign ex_mem_rd     = ex_q.mem_rd;
    assign ex_mem_wr     = ex_q.mem_wr;
    assign ex_branch     = ex_q.branch;
    assign ex_wr_addr    = ex_q.wr_addr;
    assign alu_function  = ex_q.fn;
    assign alu_src1      = ex_q.src1;
    assign alu_src2      = ex_q.src2;
    assign ex_store_data = ex_q.store;
    assign shamt         = ex_q.shamt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios followed by random traffic against an instruction-level model.
`ifndef ALU_ADD
`define ALU_ADD 4'd0
`endif
`ifndef ALU_SUB
`define ALU_SUB 4'd1
`endif
`ifndef ALU_SLL
`define ALU_SLL 4'd2
`endif

module tb_id_ex_stage;
    logic        clk = 1'b0;
    logic        rst = 1'b0, id_valid = 1'b0, stall = 1'b0, flush = 1'b0;
    logic [5:0]  id_opcode = '0, id_funct = '0;
    logic [4:0]  id_shamt = '0, id_rs = '0, id_rt = '0, id_rd = '0;
    logic [31:0] id_rs_data = '0, id_rt_data = '0;
    logic [15:0] id_imm = '0;
    logic        exm_wr_en = 1'b0, wb_wr_en = 1'b0;
    logic [4:0]  exm_wr_addr = '0, wb_wr_addr = '0;
    logic [31:0] exm_wr_data = '0, wb_wr_data = '0;
    logic        hazard_stall, illegal_op, ex_valid, ex_wr_en, ex_mem_rd, ex_mem_wr, ex_branch;
    logic [4:0]  ex_wr_addr, shamt;
    logic [3:0]  alu_function;
    logic [31:0] alu_src1, alu_src2, ex_store_data;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode), .id_funct(id_funct),
        .id_shamt(id_shamt), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .stall(stall), .flush(flush),
        .exm_wr_en(exm_wr_en), .exm_wr_addr(exm_wr_addr), .exm_wr_data(exm_wr_data),
        .wb_wr_en(wb_wr_en), .wb_wr_addr(wb_wr_addr), .wb_wr_data(wb_wr_data),
        .hazard_stall(hazard_stall), .illegal_op(illegal_op), .ex_valid(ex_valid),
        .ex_wr_en(ex_wr_en), .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr), .ex_branch(ex_branch),
        .ex_wr_addr(ex_wr_addr), .alu_function(alu_function), .alu_src1(alu_src1),
        .alu_src2(alu_src2), .ex_store_data(ex_store_data), .shamt(shamt)
    );

    typedef struct {
        bit          valid, wr_en, mem_rd, mem_wr, branch, rt_store;
        logic [4:0]  wr_addr, shamt, rs, rt;
        logic [3:0]  fn;
        logic [31:0] src1, src2, store;
    } slot_t;

    int    total = 0, bad = 0;
    slot_t m;
    bit    m_ill = 0, m_pend = 0, exp_hz = 0;
    logic [4:0] m_paddr = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic slot_t empty_slot();
        slot_t s;
        s = '{default: '0};
        s.fn = `ALU_ADD;
        return s;
    endfunction

    function automatic bit uses_rt(input logic [5:0] op);
        return op == 6'h00 || op == 6'h2B || op == 6'h04;
    endfunction

    function automatic logic [31:0] operand(input logic [4:0] idx, input logic [31:0] rf);
        if (idx == 0) return 32'd0;
        if (exm_wr_en && exm_wr_addr == idx) return exm_wr_data;
        if (wb_wr_en && wb_wr_addr == idx) return wb_wr_data;
        return rf;
    endfunction

    function automatic bit reads_reg(input logic [4:0] a);
        return a != 0 && (id_rs == a || (uses_rt(id_opcode) && id_rt == a));
    endfunction

    task automatic model_step();
        bit legal;
        logic [3:0]  fn;
        logic [4:0]  dest;
        logic [31:0] rsv, rtv;
        legal = 1;
        fn = `ALU_ADD;
        if (id_opcode == 6'h00) begin
            if (id_funct == 6'h20) fn = `ALU_ADD;
            else if (id_funct == 6'h22) fn = `ALU_SUB;
            else if (id_funct == 6'h00) fn = `ALU_SLL;
            else legal = 0;
        end else if (id_opcode == 6'h04) fn = `ALU_SUB;
        else if (!(id_opcode == 6'h08 || id_opcode == 6'h23 || id_opcode == 6'h2B)) legal = 0;

        if (rst || flush) begin
            m = empty_slot(); m_pend = 0; m_ill = 0;
        end else if (stall) begin
            m_ill = 0;
            if (m.valid && wb_wr_en && wb_wr_addr != 0) begin
                if (m.rs == wb_wr_addr) m.src1 = wb_wr_data;
                if (m.rt == wb_wr_addr) begin
                    if (m.rt_store) m.store = wb_wr_data;
                    else m.src2 = wb_wr_data;
                end
            end
        end else if (exp_hz) begin
            if (m_pend) m_pend = 0;
            else begin m_pend = 1; m_paddr = m.wr_addr; end
            m = empty_slot(); m_ill = 0;
        end else begin
            m_pend = 0;
            m = empty_slot();
            m_ill = id_valid && !legal;
            if (id_valid && legal) begin
                dest = (id_opcode == 6'h00) ? id_rd :
                       (id_opcode == 6'h08 || id_opcode == 6'h23) ? id_rt : 5'd0;
                rsv = operand(id_rs, id_rs_data);
                rtv = operand(id_rt, id_rt_data);
                m.valid    = 1;
                m.wr_addr  = dest;
                m.wr_en    = dest != 0;
                m.mem_rd   = id_opcode == 6'h23;
                m.mem_wr   = id_opcode == 6'h2B;
                m.branch   = id_opcode == 6'h04;
                m.fn       = fn;
                m.src1     = rsv;
                m.src2     = (id_opcode == 6'h00 || id_opcode == 6'h04) ? rtv : {{16{id_imm[15]}}, id_imm};
                m.store    = m.mem_wr ? rtv : 32'd0;
                m.shamt    = (id_opcode == 6'h00 && id_funct == 6'h00) ? id_shamt : 5'd0;
                m.rs       = id_rs;
                m.rt       = uses_rt(id_opcode) ? id_rt : 5'd0;
                m.rt_store = m.mem_wr;
            end
        end
    endtask

    task automatic cycle();
        #1;
        exp_hz = !rst && !flush && !stall && id_valid &&
                 ((m.valid && m.mem_rd && reads_reg(m.wr_addr)) || (m_pend && reads_reg(m_paddr)));
        chk("hazard_stall", {31'd0, hazard_stall}, {31'd0, exp_hz});
        model_step();
        @(posedge clk);
        #1;
        chk("ex_valid", {31'd0, ex_valid}, {31'd0, m.valid});
        chk("ex_wr_en", {31'd0, ex_wr_en}, {31'd0, m.wr_en});
        chk("ex_mem_rd", {31'd0, ex_mem_rd}, {31'd0, m.mem_rd});
        chk("ex_mem_wr", {31'd0, ex_mem_wr}, {31'd0, m.mem_wr});
        chk("ex_branch", {31'd0, ex_branch}, {31'd0, m.branch});
        chk("ex_wr_addr", {27'd0, ex_wr_addr}, {27'd0, m.wr_addr});
        chk("alu_function", {28'd0, alu_function}, {28'd0, m.fn});
        chk("alu_src1", alu_src1, m.src1);
        chk("alu_src2", alu_src2, m.src2);
        chk("ex_store_data", ex_store_data, m.store);
        chk("shamt", {27'd0, shamt}, {27'd0, m.shamt});
        chk("illegal_op", {31'd0, illegal_op}, {31'd0, m_ill});
    endtask

    task automatic set_id(input logic [5:0] op, input logic [5:0] fu, input logic [4:0] rs,
                          input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] sh,
                          input logic [15:0] imm, input logic [31:0] rsd, input logic [31:0] rtd);
        id_valid = 1; id_opcode = op; id_funct = fu; id_rs = rs; id_rt = rt; id_rd = rd;
        id_shamt = sh; id_imm = imm; id_rs_data = rsd; id_rt_data = rtd;
    endtask

    initial begin
        bit last_hz;
        m = empty_slot();

        // reset
        rst = 1; cycle(); rst = 0;
        chk("rst_valid", {31'd0, ex_valid}, 32'd0);
        chk("rst_fn", {28'd0, alu_function}, {28'd0, `ALU_ADD});
        chk("rst_src1", alu_src1, 32'd0);
        chk("rst_src2", alu_src2, 32'd0);

        // add r3,r1,r2
        set_id(6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 32'd5, 32'd7); cycle();
        chk("add_src1", alu_src1, 32'd5);
        chk("add_src2", alu_src2, 32'd7);
        chk("add_fn", {28'd0, alu_function}, {28'd0, `ALU_ADD});
        chk("add_wr_addr", {27'd0, ex_wr_addr}, 32'd3);
        chk("add_wr_en", {31'd0, ex_wr_en}, 32'd1);

        // exm beats wb on the same register
        exm_wr_en = 1; exm_wr_addr = 5'd1; exm_wr_data = 32'd100;
        wb_wr_en = 1; wb_wr_addr = 5'd1; wb_wr_data = 32'd50; cycle();
        chk("fwd_exm_wins", alu_src1, 32'd100);
        exm_wr_en = 0; wb_wr_en = 0;

        // addi r4,r0,0xFFFF
        set_id(6'h08, 6'h00, 5'd0, 5'd4, 5'd0, 5'd0, 16'hFFFF, 32'd123, 32'd0); cycle();
        chk("addi_src1", alu_src1, 32'd0);
        chk("addi_src2", alu_src2, 32'hFFFF_FFFF);

        // sll r5,r2,3
        set_id(6'h00, 6'h00, 5'd0, 5'd2, 5'd5, 5'd3, 16'h0, 32'd0, 32'd8); cycle();
        chk("sll_fn", {28'd0, alu_function}, {28'd0, `ALU_SLL});
        chk("sll_shamt", {27'd0, shamt}, 32'd3);

        // lw r2,0(r1) then dependent add r6,r2,r1
        set_id(6'h23, 6'h00, 5'd1, 5'd2, 5'd0, 5'd0, 16'h0, 32'd4, 32'd0); cycle();
        set_id(6'h00, 6'h20, 5'd2, 5'd1, 5'd6, 5'd0, 16'h0, 32'h1111, 32'd4);
        #1 chk("lu_hz_first", {31'd0, hazard_stall}, 32'd1);
        cycle();
        chk("lu_bubble1", {31'd0, ex_valid}, 32'd0);
        chk("lu_hz_second", {31'd0, hazard_stall}, 32'd1);
        cycle();
        chk("lu_bubble2", {31'd0, ex_valid}, 32'd0);
        wb_wr_en = 1; wb_wr_addr = 5'd2; wb_wr_data = 32'hDEAD;
        #1 chk("lu_hz_clear", {31'd0, hazard_stall}, 32'd0);
        cycle();
        chk("lu_src1", alu_src1, 32'hDEAD);
        chk("lu_valid", {31'd0, ex_valid}, 32'd1);
        wb_wr_en = 0;

        // sub r8,r7,r1 held by stall while r7 is written back
        set_id(6'h00, 6'h22, 5'd7, 5'd1, 5'd8, 5'd0, 16'h0, 32'd11, 32'd2); cycle();
        chk("sub_src1", alu_src1, 32'd11);
        stall = 1; wb_wr_en = 1; wb_wr_addr = 5'd7; wb_wr_data = 32'd9;
        set_id(6'h00, 6'h20, 5'd3, 5'd3, 5'd9, 5'd0, 16'h0, 32'd1, 32'd1); cycle();
        chk("stall_src1", alu_src1, 32'd9);
        chk("stall_src2", alu_src2, 32'd2);
        chk("stall_fn", {28'd0, alu_function}, {28'd0, `ALU_SUB});
        chk("stall_wr_addr", {27'd0, ex_wr_addr}, 32'd8);
        wb_wr_en = 0; flush = 1; cycle();
        chk("flush_valid", {31'd0, ex_valid}, 32'd0);
        stall = 0; flush = 0;

        // illegal opcode, then beq r1,r1
        set_id(6'h3F, 6'h00, 5'd1, 5'd1, 5'd1, 5'd0, 16'h0, 32'd3, 32'd3); cycle();
        chk("ill_pulse", {31'd0, illegal_op}, 32'd1);
        chk("ill_valid", {31'd0, ex_valid}, 32'd0);
        set_id(6'h04, 6'h00, 5'd1, 5'd1, 5'd0, 5'd0, 16'h4, 32'd3, 32'd3); cycle();
        chk("ill_drop", {31'd0, illegal_op}, 32'd0);
        chk("beq_fn", {28'd0, alu_function}, {28'd0, `ALU_SUB});
        chk("beq_branch", {31'd0, ex_branch}, 32'd1);
        chk("beq_wr_en", {31'd0, ex_wr_en}, 32'd0);

        // random traffic
        last_hz = 0;
        for (int i = 0; i < 500; i++) begin
            rst   = $urandom_range(0, 99) < 2;
            flush = $urandom_range(0, 99) < 8;
            stall = $urandom_range(0, 99) < 15;
            if (!last_hz) begin
                case ($urandom_range(0, 8))
                    0: begin id_opcode = 6'h00; id_funct = 6'h20; end
                    1: begin id_opcode = 6'h00; id_funct = 6'h22; end
                    2: begin id_opcode = 6'h00; id_funct = 6'h00; end
                    3: begin id_opcode = 6'h08; id_funct = 6'($urandom); end
                    4, 5: begin id_opcode = 6'h23; id_funct = 6'($urandom); end
                    6: begin id_opcode = 6'h2B; id_funct = 6'($urandom); end
                    7: begin id_opcode = 6'h04; id_funct = 6'($urandom); end
                    default: begin id_opcode = 6'($urandom); id_funct = 6'($urandom); end
                endcase
                id_valid = $urandom_range(0, 9) != 0;
                id_rs = 5'($urandom_range(0, 7)); id_rt = 5'($urandom_range(0, 7));
                id_rd = 5'($urandom_range(0, 7)); id_shamt = 5'($urandom);
                id_imm = 16'($urandom); id_rs_data = $urandom; id_rt_data = $urandom;
            end
            exm_wr_en = $urandom_range(0, 2) == 0; exm_wr_addr = 5'($urandom_range(0, 7));
            exm_wr_data = $urandom;
            wb_wr_en = $urandom_range(0, 1) == 0; wb_wr_addr = 5'($urandom_range(0, 7));
            wb_wr_data = $urandom;
            cycle();
            last_hz = exp_hz;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
